// File: rtl/hazard_pkg.sv
// Shared opcode constants, pipeline record type and state encoding for the
// forwarding / load-use hazard unit of the pipelined MIPS core.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Destination record carried alongside an instruction through EX and MEM.
  typedef struct packed {
    logic       wr;
    logic [4:0] dest;
    logic       is_load;
  } pipe_rec_t;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/forward_hazard_unit_decode.sv
// Combinational decode of the IF/ID instruction into source register fields,
// source-usage flags and the destination record it will carry down the pipe.
module instr_decode #(
  parameter logic [5:0] OP_LW = hazard_pkg::OP_LW
) (
  input  logic [31:0]           instr_i,
  output logic [4:0]            rs_o,
  output logic [4:0]            rt_o,
  output logic                  uses_rs_o,
  output logic                  uses_rt_o,
  output hazard_pkg::pipe_rec_t rec_o
);
  import hazard_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rdField;
  logic       readsRs;
  logic       readsRt;
  logic [4:0] destReg;
  logic       isLoad;
  logic       unusedShamt;

  assign opcode      = instr_i[31:26];
  assign funct       = instr_i[5:0];
  assign rdField     = instr_i[15:11];
  assign rs_o        = instr_i[25:21];
  assign rt_o        = instr_i[20:16];
  assign unusedShamt = ^instr_i[10:6];

  // Classify the instruction; the load test comes first so an overridden
  // load opcode always wins over the fixed opcode list below.
  always_comb begin
    readsRs = 1'b0;
    readsRt = 1'b0;
    destReg = 5'd0;
    isLoad  = 1'b0;
    if (opcode == OP_RTYPE) begin
      readsRs = 1'b1;
      if (funct != FN_JR) begin
        readsRt = 1'b1;
        destReg = rdField;
      end
    end else if (opcode == OP_LW) begin
      readsRs = 1'b1;
      destReg = rt_o;
      isLoad  = 1'b1;
    end else begin
      case (opcode)
        OP_SW, OP_BEQ, OP_BNE: begin
          readsRs = 1'b1;
          readsRt = 1'b1;
        end
        OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: begin
          readsRs = 1'b1;
          destReg = rt_o;
        end
        default: begin
          readsRs = 1'b0;
        end
      endcase
    end
  end

  // r0 is hardwired zero: reading it never needs forwarding and writing it
  // is not a real write.
  always_comb begin
    uses_rs_o     = readsRs && (rs_o != 5'd0);
    uses_rt_o     = readsRt && (rt_o != 5'd0);
    rec_o.wr      = destReg != 5'd0;
    rec_o.dest    = destReg;
    rec_o.is_load = isLoad && (destReg != 5'd0);
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding select and load-use stall control for the pipelined MIPS
// datapath. Tracks EX and MEM destination records, drives the four operand
// forwarding selects, inserts one stall/bubble per load-use pair and counts
// stall cycles with a saturating counter.
module forward_hazard_unit #(
  parameter int         CNT_W = 16,
  parameter logic [5:0] OP_LW = hazard_pkg::OP_LW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  output logic             ex_forward_a,
  output logic             ex_forward_b,
  output logic             mem_forward_a,
  output logic             mem_forward_b,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count
);
  import hazard_pkg::*;

  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       decUsesRs;
  logic       decUsesRt;
  logic       usesRs;
  logic       usesRt;
  pipe_rec_t  idRec;
  logic       hazard;

  pipe_rec_t  exRec_q;
  pipe_rec_t  exRec_d;
  pipe_rec_t  memRec_q;
  hz_state_t  state_q;
  hz_state_t  state_d;
  logic [CNT_W-1:0] stallCount_q;
  logic [CNT_W-1:0] stallCount_d;

  instr_decode #(
    .OP_LW(OP_LW)
  ) u_decode (
    .instr_i   (id_instr),
    .rs_o      (idRs),
    .rt_o      (idRt),
    .uses_rs_o (decUsesRs),
    .uses_rt_o (decUsesRt),
    .rec_o     (idRec)
  );

  // An invalid IF/ID slot is a NOP, so it reads nothing.
  assign usesRs = decUsesRs && id_valid;
  assign usesRt = decUsesRt && id_valid;

  // Forwarding selects; a load in EX has no data yet, so only MEM may forward it.
  always_comb begin
    ex_forward_a  = exRec_q.wr && !exRec_q.is_load && (exRec_q.dest == idRs) && usesRs;
    ex_forward_b  = exRec_q.wr && !exRec_q.is_load && (exRec_q.dest == idRt) && usesRt;
    mem_forward_a = memRec_q.wr && (memRec_q.dest == idRs) && usesRs;
    mem_forward_b = memRec_q.wr && (memRec_q.dest == idRt) && usesRt;
  end

  // Load-use detection and the stall/bubble request; after one stall the
  // load sits in MEM and its value forwards, so LSTALL never stalls.
  always_comb begin
    hazard = id_valid && exRec_q.wr && exRec_q.is_load &&
             ((usesRs && (idRs == exRec_q.dest)) || (usesRt && (idRt == exRec_q.dest)));
    stall  = (state_q == RUN) && hazard;
    bubble = stall;
  end

  // Next-state values for the records, FSM and saturating counter.
  always_comb begin
    exRec_d = (!stall && id_valid) ? idRec : '0;
    stallCount_d = stallCount_q;
    if (stall && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + CNT_W'(1);
    end
    state_d = RUN;
    case (state_q)
      RUN:     state_d = hazard ? LSTALL : RUN;
      LSTALL:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // All state advances together; reset clears records, FSM and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      exRec_q      <= '0;
      memRec_q     <= '0;
      state_q      <= RUN;
      stallCount_q <= '0;
    end else begin
      exRec_q      <= exRec_d;
      memRec_q     <= exRec_q;
      state_q      <= state_d;
      stallCount_q <= stallCount_d;
    end
  end

  assign stall_count = stallCount_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: hand-computed forwarding, stall and
// counter expectations, plus a narrow-counter instance for saturation.
module tb_forward_hazard_unit;

  logic        clk;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;

  logic        exFa, exFb, memFa, memFb, stall, bubble;
  logic [15:0] stallCount;
  logic        satExFa, satExFb, satMemFa, satMemFb, satStall, satBubble;
  logic [1:0]  satCount;

  int checks = 0;
  int errors = 0;

  forward_hazard_unit dut (
    .clk           (clk),
    .rst           (rst),
    .id_instr      (id_instr),
    .id_valid      (id_valid),
    .ex_forward_a  (exFa),
    .ex_forward_b  (exFb),
    .mem_forward_a (memFa),
    .mem_forward_b (memFb),
    .stall         (stall),
    .bubble        (bubble),
    .stall_count   (stallCount)
  );

  forward_hazard_unit #(.CNT_W(2)) dutSat (
    .clk           (clk),
    .rst           (rst),
    .id_instr      (id_instr),
    .id_valid      (id_valid),
    .ex_forward_a  (satExFa),
    .ex_forward_b  (satExFb),
    .mem_forward_a (satMemFa),
    .mem_forward_b (satMemFb),
    .stall         (satStall),
    .bubble        (satBubble),
    .stall_count   (satCount)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid);
    id_instr = instr;
    id_valid = valid;
    #2;
  endtask

  task automatic checkBit(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic fa, input logic fb, input logic ma,
                             input logic mb, input logic st, input logic [15:0] cnt);
    checkBit({tag, ".exFa"}, {15'd0, exFa}, {15'd0, fa});
    checkBit({tag, ".exFb"}, {15'd0, exFb}, {15'd0, fb});
    checkBit({tag, ".memFa"}, {15'd0, memFa}, {15'd0, ma});
    checkBit({tag, ".memFb"}, {15'd0, memFb}, {15'd0, mb});
    checkBit({tag, ".stall"}, {15'd0, stall}, {15'd0, st});
    checkBit({tag, ".bubble"}, {15'd0, bubble}, {15'd0, st});
    checkBit({tag, ".count"}, stallCount, cnt);
  endtask

  task automatic flush();
    applyStimulus(32'd0, 1'b0);
    nextCycle();
    applyStimulus(32'd0, 1'b0);
    nextCycle();
  endtask

  // Directed sequence of pipeline scenarios.
  initial begin
    rst = 1'b1;
    id_instr = 32'd0;
    id_valid = 1'b0;
    nextCycle();
    nextCycle();
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1);
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    checkBit("reset.satCount", {14'd0, satCount}, 16'd0);
    rst = 1'b0;
    flush();

    $display("[TB] dependent ALU ops");
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1);
    checkOutput("alu.add", 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(rtype(5'd3, 5'd5, 5'd4, 6'h22), 1'b1);
    checkOutput("alu.sub", 1, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(rtype(5'd3, 5'd0, 5'd7, 6'h25), 1'b1);
    checkOutput("alu.memA", 0, 0, 1, 0, 0, 0);
    nextCycle();
    flush();
    applyStimulus(rtype(5'd1, 5'd2, 5'd10, 6'h20), 1'b1);
    nextCycle();
    applyStimulus(rtype(5'd10, 5'd10, 5'd11, 6'h20), 1'b0);
    checkOutput("alu.nop", 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(rtype(5'd10, 5'd0, 5'd11, 6'h25), 1'b1);
    checkOutput("alu.afterNop", 0, 0, 1, 0, 0, 0);
    nextCycle();
    flush();

    $display("[TB] load-use");
    applyStimulus(itype(6'h23, 5'd0, 5'd8, 16'd0), 1'b1);
    checkOutput("lu.lw", 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(rtype(5'd8, 5'd8, 5'd9, 6'h20), 1'b1);
    checkOutput("lu.stall", 0, 0, 0, 0, 1, 0);
    nextCycle();
    checkOutput("lu.release", 0, 0, 1, 1, 0, 1);
    nextCycle();
    flush();

    $display("[TB] r0 writes");
    applyStimulus(itype(6'h08, 5'd0, 5'd0, 16'd5), 1'b1);
    nextCycle();
    applyStimulus(rtype(5'd0, 5'd0, 5'd1, 6'h20), 1'b1);
    checkOutput("r0.add", 0, 0, 0, 0, 0, 1);
    nextCycle();
    flush();

    $display("[TB] double hazard");
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1);
    nextCycle();
    applyStimulus(rtype(5'd4, 5'd5, 5'd3, 6'h20), 1'b1);
    checkOutput("dbl.second", 0, 0, 0, 0, 0, 1);
    nextCycle();
    applyStimulus(rtype(5'd3, 5'd3, 5'd6, 6'h25), 1'b1);
    checkOutput("dbl.or", 1, 1, 1, 1, 0, 1);
    nextCycle();
    flush();

    $display("[TB] store and branch rt path");
    applyStimulus(itype(6'h23, 5'd1, 5'd2, 16'd0), 1'b1);
    nextCycle();
    applyStimulus(itype(6'h2b, 5'd1, 5'd2, 16'd4), 1'b1);
    checkOutput("sw.stall", 0, 0, 0, 0, 1, 1);
    nextCycle();
    checkOutput("sw.release", 0, 0, 0, 1, 0, 2);
    nextCycle();
    applyStimulus(itype(6'h08, 5'd0, 5'd7, 16'd1), 1'b1);
    nextCycle();
    applyStimulus(itype(6'h04, 5'd7, 5'd0, 16'd3), 1'b1);
    checkOutput("beq.fwd", 1, 0, 0, 0, 0, 2);
    nextCycle();
    flush();

    $display("[TB] reset mid-stall");
    applyStimulus(itype(6'h23, 5'd0, 5'd8, 16'd0), 1'b1);
    nextCycle();
    applyStimulus(rtype(5'd8, 5'd8, 5'd9, 6'h20), 1'b1);
    checkOutput("rst.stall", 0, 0, 0, 0, 1, 2);
    nextCycle();
    checkOutput("rst.lstall", 0, 0, 1, 1, 0, 3);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    #2;
    checkOutput("rst.after", 0, 0, 0, 0, 0, 0);
    checkBit("rst.satCount", {14'd0, satCount}, 16'd0);
    nextCycle();
    flush();

    $display("[TB] counter saturation");
    for (int p = 0; p < 5; p++) begin
      applyStimulus(itype(6'h23, 5'd0, 5'd8, 16'd0), 1'b1);
      nextCycle();
      applyStimulus(rtype(5'd8, 5'd8, 5'd9, 6'h20), 1'b1);
      checkBit("sat.pairStall", {15'd0, stall}, 16'd1);
      nextCycle();
      applyStimulus(rtype(5'd8, 5'd8, 5'd9, 6'h20), 1'b1);
      nextCycle();
    end
    checkBit("sat.mainCount", stallCount, 16'd5);
    checkBit("sat.satCount", {14'd0, satCount}, 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
